// File: rtl/fetch_pkg.sv
// Shared types and widths for the boot/fetch front end.
package fetch_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned PID_W   = 5;
   localparam int unsigned NUM_PID = 1 << PID_W;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [PID_W-1:0]  pid_t;

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_HALT
   } state_e;

   // Address arithmetic wraps modulo 2^32.
   function automatic word_t add_w(input word_t a, input word_t b);
      return a + b;
   endfunction

endpackage

// File: rtl/boot_fetch_unit_if.sv
// Datapath, HD and instruction-memory signals of the boot/fetch unit.
interface boot_fetch_unit_if;
   import fetch_pkg::*;

   word_t InputPC;
   logic  Halt;
   logic  Resume;
   pid_t  PID_CPU;
   logic  BaseWr;
   pid_t  BaseWrPID;
   word_t BaseWrData;
   word_t HD_Addr;
   word_t HD_Data;
   word_t IM_Addr;
   word_t IM_WrData;
   logic  IM_Wr;
   word_t Endereco;
   word_t DeslocamentoMemoria;
   word_t PC;
   logic  Running;
   logic  BootDone;
   logic  Fault;

   // Fetch unit side.
   modport master (
      input  InputPC, Halt, Resume, PID_CPU, BaseWr, BaseWrPID, BaseWrData, HD_Data,
      output HD_Addr, IM_Addr, IM_WrData, IM_Wr, Endereco, DeslocamentoMemoria,
             PC, Running, BootDone, Fault
   );

   // Datapath / memory environment side.
   modport slave (
      output InputPC, Halt, Resume, PID_CPU, BaseWr, BaseWrPID, BaseWrData, HD_Data,
      input  HD_Addr, IM_Addr, IM_WrData, IM_Wr, Endereco, DeslocamentoMemoria,
             PC, Running, BootDone, Fault
   );

endinterface

// File: rtl/base_table.sv
// Per-process relocation base register file: one sync write port, one comb read port.
module base_table
   import fetch_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  we_i,
   input  pid_t  wr_pid_i,
   input  word_t wr_data_i,
   input  pid_t  rd_pid_i,
   output word_t rd_data_o
);

   word_t mem_q [NUM_PID];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q <= '{default: '0};
      end else if (we_i) begin
         mem_q[wr_pid_i] <= wr_data_i;
      end
   end

   // Read returns the pre-write value on a same-cycle write.
   assign rd_data_o = mem_q[rd_pid_i];

endmodule

// File: rtl/boot_fetch_unit.sv
// Boot copier (HD -> instruction memory) followed by PC/fetch control.
// Optional macro BOUNDS_CHECK_EN adds a per-process code-size fault.
module boot_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned BOOT_WORDS   = 256,
   parameter int unsigned HD_BIOS_BASE = 0,
   parameter int unsigned IM_BIOS_BASE = 0,
   parameter int unsigned PROC_LIMIT   = 1024
) (
   input logic               Clock,
   input logic               Reset,
   boot_fetch_unit_if.master bus
);

   localparam word_t BOOT_LAST = WORD_W'(BOOT_WORDS);
   localparam word_t HD_BASE_W = WORD_W'(HD_BIOS_BASE);
   localparam word_t IM_BASE_W = WORD_W'(IM_BIOS_BASE);

   state_e state_q;
   word_t  pc_q;
   word_t  cnt_q;
   word_t  hd_addr_q;
   word_t  im_addr_q;
   logic   im_wr_q;
   logic   running_q;
   logic   boot_done_q;
   logic   fault_q;
   word_t  base_rd;

`ifdef BOUNDS_CHECK_EN
   localparam word_t LIMIT_W = WORD_W'(PROC_LIMIT);
   logic oob_c;
   // Kernel (PID 0) may jump anywhere.
   assign oob_c = (bus.InputPC >= LIMIT_W) && (bus.PID_CPU != '0);
`else
   logic unused_limit;
   assign unused_limit = |WORD_W'(PROC_LIMIT);
   assign fault_q      = 1'b0;
`endif

   base_table u_base_table (
      .clk_i     (Clock),
      .rst_i     (Reset),
      .we_i      (bus.BaseWr),
      .wr_pid_i  (bus.BaseWrPID),
      .wr_data_i (bus.BaseWrData),
      .rd_pid_i  (bus.PID_CPU),
      .rd_data_o (base_rd)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= S_BOOT;
         pc_q        <= IM_BASE_W;
         cnt_q       <= '0;
         hd_addr_q   <= HD_BASE_W;
         im_addr_q   <= IM_BASE_W;
         im_wr_q     <= 1'b0;
         running_q   <= 1'b0;
         boot_done_q <= 1'b0;
`ifdef BOUNDS_CHECK_EN
         fault_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            // HD read latency is one cycle, so the IM write trails HD_Addr by one word.
            S_BOOT: begin
               if (cnt_q == BOOT_LAST) begin
                  state_q     <= S_RUN;
                  running_q   <= 1'b1;
                  boot_done_q <= 1'b1;
                  im_wr_q     <= 1'b0;
                  pc_q        <= IM_BASE_W;
               end else begin
                  cnt_q     <= add_w(cnt_q, WORD_W'(1));
                  hd_addr_q <= add_w(hd_addr_q, WORD_W'(1));
                  im_addr_q <= add_w(IM_BASE_W, cnt_q);
                  im_wr_q   <= 1'b1;
               end
            end
            S_RUN: begin
               if (bus.Halt) begin
                  state_q   <= S_HALT;
                  running_q <= 1'b0;
               end
`ifdef BOUNDS_CHECK_EN
               else if (oob_c) begin
                  fault_q   <= 1'b1;
                  state_q   <= S_HALT;
                  running_q <= 1'b0;
               end
`endif
               else begin
                  pc_q <= bus.InputPC;
               end
            end
            S_HALT: begin
               if (bus.Resume && !fault_q) begin
                  pc_q      <= add_w(pc_q, WORD_W'(1));
                  state_q   <= S_RUN;
                  running_q <= 1'b1;
               end
            end
            default: state_q <= S_BOOT;
         endcase
      end
   end

   assign bus.HD_Addr             = hd_addr_q;
   assign bus.IM_Addr             = im_addr_q;
   assign bus.IM_Wr               = im_wr_q;
   assign bus.IM_WrData           = bus.HD_Data;
   assign bus.PC                  = pc_q;
   assign bus.Running             = running_q;
   assign bus.BootDone            = boot_done_q;
   assign bus.Fault               = fault_q;
   assign bus.DeslocamentoMemoria = base_rd;
   assign bus.Endereco            = add_w(pc_q, base_rd);

endmodule

// File: tb/tb_boot_fetch_unit.sv
// Randomized self-checking bench for boot_fetch_unit against a behavioural model.
module tb_boot_fetch_unit;

   localparam int unsigned BW  = 4;
   localparam logic [31:0] HDB = 32'h10;
   localparam logic [31:0] IMB = 32'h4;
   localparam logic [31:0] LIM = 32'd1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   boot_fetch_unit_if bus ();

   boot_fetch_unit #(
      .BOOT_WORDS   (BW),
      .HD_BIOS_BASE (HDB),
      .IM_BIOS_BASE (IMB),
      .PROC_LIMIT   (LIM)
   ) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   logic [31:0] hd_mem [64];
   logic [31:0] im_mem [64];

   // HD returns the addressed word one cycle later; IM captures writes.
   always @(posedge clk) begin
      bus.HD_Data <= hd_mem[bus.HD_Addr[5:0]];
      if (bus.IM_Wr === 1'b1) im_mem[bus.IM_Addr[5:0]] <= bus.IM_WrData;
   end

   // Behavioural model: mode 0 = booting, 1 = running, 2 = halted.
   int          m_mode;
   int unsigned m_k;
   logic [31:0] m_pc;
   logic [31:0] m_base [32];
   bit          m_done;
   bit          m_fault;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      logic [31:0] a;
      logic [31:0] b;
      b = m_base[bus.PID_CPU];
      chk("pc", bus.PC, m_pc);
      chk("running", 32'(bus.Running), 32'(m_mode == 1));
      chk("bootdone", 32'(bus.BootDone), 32'(m_done));
      chk("fault", 32'(bus.Fault), 32'(m_fault));
      chk("deslocamento", bus.DeslocamentoMemoria, b);
      chk("endereco", bus.Endereco, m_pc + b);
      chk("im_wr", 32'(bus.IM_Wr), 32'(m_mode == 0 && m_k >= 1));
      if (m_mode == 0) begin
         chk("hd_addr", bus.HD_Addr, HDB + m_k);
         if (m_k >= 1) begin
            a = HDB + m_k - 1;
            chk("im_addr", bus.IM_Addr, IMB + m_k - 1);
            chk("im_wrdata", bus.IM_WrData, hd_mem[a[5:0]]);
         end
      end
   endtask

   task automatic advance_model();
      if (rst) begin
         m_mode  = 0;
         m_k     = 0;
         m_pc    = IMB;
         m_done  = 0;
         m_fault = 0;
         for (int i = 0; i < 32; i++) m_base[i] = '0;
      end else begin
         case (m_mode)
            0: begin
               if (m_k == BW) begin
                  m_mode = 1;
                  m_done = 1;
                  m_pc   = IMB;
               end else begin
                  m_k++;
               end
            end
            1: begin
               if (bus.Halt) m_mode = 2;
`ifdef BOUNDS_CHECK_EN
               else if (bus.InputPC >= LIM && bus.PID_CPU != 0) begin
                  m_fault = 1;
                  m_mode  = 2;
               end
`endif
               else m_pc = bus.InputPC;
            end
            default: begin
               if (bus.Resume && !m_fault) begin
                  m_pc   = m_pc + 1;
                  m_mode = 1;
               end
            end
         endcase
         if (bus.BaseWr) m_base[bus.BaseWrPID] = bus.BaseWrData;
      end
   endtask

   // Check this cycle, step the model across the coming edge, land on the next negedge.
   task automatic tick();
      #1;
      check_model();
      advance_model();
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         hd_mem[i] = $urandom;
         im_mem[i] = '0;
      end
      for (int i = 0; i < 4; i++) hd_mem[16 + i] = 32'hA0 + i;
      bus.InputPC = '0; bus.Halt = 0; bus.Resume = 0; bus.PID_CPU = '0;
      bus.BaseWr = 0; bus.BaseWrPID = '0; bus.BaseWrData = '0;
      rst = 1;
      advance_model();
      @(negedge clk);
      tick();
      chk("rst_pc", bus.PC, 32'h4);
      chk("rst_hd_addr", bus.HD_Addr, 32'h10);
      chk("rst_running", 32'(bus.Running), 32'd0);
      chk("rst_bootdone", 32'(bus.BootDone), 32'd0);
      chk("rst_im_wr", 32'(bus.IM_Wr), 32'd0);

      // Boot copy with Halt/Resume asserted (must be ignored).
      rst = 0; bus.Halt = 1; bus.Resume = 1;
      for (int i = 0; i < 4; i++) tick();
      bus.Halt = 0; bus.Resume = 0;
      tick();
      chk("boot_running", 32'(bus.Running), 32'd1);
      chk("boot_pc", bus.PC, 32'h4);
      chk("boot_done", 32'(bus.BootDone), 32'd1);
      for (int i = 0; i < 4; i++) chk("boot_im_word", im_mem[4 + i], 32'hA0 + 32'(i));

      // Relocation and same-cycle base write.
      bus.BaseWr = 1; bus.BaseWrPID = 5'd3; bus.BaseWrData = 32'h100;
      bus.PID_CPU = 5'd3; bus.InputPC = 32'h10;
      tick();
      bus.BaseWrData = 32'h200;
      #1;
      chk("reloc_endereco_old", bus.Endereco, 32'h110);
      chk("reloc_desloc_old", bus.DeslocamentoMemoria, 32'h100);
      tick();
      bus.BaseWr = 0;
      #1;
      chk("reloc_endereco_new", bus.Endereco, 32'h210);
      tick();

      // Halt / resume.
      bus.InputPC = 32'h20;
      tick();
      bus.Halt = 1; bus.InputPC = 32'h55;
      tick();
      chk("halt_pc", bus.PC, 32'h20);
      chk("halt_running", 32'(bus.Running), 32'd0);
      bus.Resume = 1;
      tick();
      chk("resume_pc", bus.PC, 32'h21);
      chk("resume_running", 32'(bus.Running), 32'd1);
      bus.Halt = 0; bus.InputPC = 32'h30;
      tick();
      chk("resume_in_run_pc", bus.PC, 32'h30);
      bus.Resume = 0;

      // Address wrap.
      bus.BaseWr = 1; bus.BaseWrPID = 5'd5; bus.BaseWrData = 32'hFFFF_FFF0;
      bus.PID_CPU = 5'd5; bus.InputPC = 32'h20;
      tick();
      bus.BaseWr = 0;
      tick();
      chk("wrap_endereco", bus.Endereco, 32'h10);

      // Reset in the middle of the copy.
      rst = 1; tick(); rst = 0;
      tick(); tick();
      rst = 1; tick(); rst = 0;
      chk("midboot_hd_addr", bus.HD_Addr, 32'h10);
      chk("midboot_bootdone", 32'(bus.BootDone), 32'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("midboot_not_done", 32'(bus.BootDone), 32'd0);
      tick();
      chk("midboot_done", 32'(bus.BootDone), 32'd1);

      // Random traffic, with occasional resets.
      for (int c = 0; c < 600; c++) begin
         rst            = ($urandom_range(0, 99) == 0);
         bus.Halt       = ($urandom_range(0, 99) < 15);
         bus.Resume     = ($urandom_range(0, 99) < 25);
         bus.PID_CPU    = 5'($urandom);
         bus.BaseWr     = ($urandom_range(0, 99) < 25);
         bus.BaseWrPID  = 5'($urandom);
         bus.BaseWrData = $urandom;
         bus.InputPC    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2047)) : $urandom;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/boot_fetch_unit.md
Name: boot_fetch_unit

Overview:
- Front end of the single-cycle core; sits directly upstream of the datapath and owns the program counter.
- After reset, copies the BIOS image from the simulated HD into instruction memory, then runs fetch.
- Fetch produces the physical fetch address `Endereco` = PC + base of the current process, and the relocation offset `DeslocamentoMemoria`.
- Accepts next-PC (`InputPC`) and `Halt` from the datapath and I/O module.

Parameters:
- BOOT_WORDS, 256, number of 32-bit words copied from HD to instruction memory at boot (>=1).
- HD_BIOS_BASE, 0, HD word address of the first BIOS word.
- IM_BIOS_BASE, 0, instruction-memory word address receiving the first BIOS word; also the first PC value.
- PROC_LIMIT, 1024, per-process code-size limit in words (used only with BOUNDS_CHECK_EN).

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high.
- InputPC  in  32  next PC computed by the datapath.
- Halt  in  1  halt request from the I/O module.
- Resume  in  1  single-cycle pulse; leave HALT.
- PID_CPU  in  5  current process id.
- BaseWr  in  1  write enable for the base table.
- BaseWrPID  in  5  base table write index.
- BaseWrData  in  32  base value to write.
- HD_Addr  out  32  HD read address.
- HD_Data  in  32  HD read data; synchronous, valid one cycle after HD_Addr.
- IM_Addr  out  32  instruction-memory write address.
- IM_WrData  out  32  instruction-memory write data.
- IM_Wr  out  1  instruction-memory write strobe.
- Endereco  out  32  fetch address to instruction memory.
- DeslocamentoMemoria  out  32  base of PID_CPU.
- PC  out  32  architectural (relative) PC.
- Running  out  1  high only in S_RUN.
- BootDone  out  1  sticky high once the copy completes.
- Fault  out  1  sticky bounds fault; constant 0 without BOUNDS_CHECK_EN.

Behaviour:
- Interface: one clock `Clock`; `Reset` is synchronous and active-high.
- Reset values:
  - State S_BOOT, PC=IM_BIOS_BASE, copy counter=0.
  - IM_Wr=0, HD_Addr=HD_BIOS_BASE, BootDone=0, Running=0, Fault=0.
  - All 32 base-table entries = 0.
- States: S_BOOT, S_RUN, S_HALT.
- S_BOOT (pipelined copy):
  - In cycle k (k=0..BOOT_WORDS), HD_Addr=HD_BIOS_BASE+k.
  - For k>=1: IM_Wr=1, IM_Addr=IM_BIOS_BASE+k-1, IM_WrData=HD_Data.
  - The copy occupies BOOT_WORDS+1 cycles, then the unit enters S_RUN with PC=IM_BIOS_BASE and BootDone=1.
  - In S_BOOT, Halt and Resume are ignored and PC is held.
- S_RUN:
  - Each edge: PC<=InputPC, unless Halt=1, in which case PC is held and state goes to S_HALT.
- S_HALT:
  - PC is held.
  - Resume=1 gives PC<=PC+1 and state S_RUN.
  - Halt and Resume both high in S_HALT: Resume wins.
  - A Resume pulse in S_RUN or S_BOOT is ignored.
- Combinational outputs: Endereco = PC + base[PID_CPU]; DeslocamentoMemoria = base[PID_CPU].
- Arithmetic: all 32-bit; addition wraps modulo 2^32, no carry out.
- Base table:
  - Written on the edge when BaseWr=1.
  - A same-cycle read of the same PID returns the old value; the new value is visible the next cycle.
  - Writes are accepted in every state.
- Reset mid-copy restarts the copy from word 0. Partial IM contents are simply overwritten.
- IM_Wr is 0 outside S_BOOT.

Optional Feature:
- Macro: BOUNDS_CHECK_EN.
- With the macro: in S_RUN, if InputPC >= PROC_LIMIT and PID_CPU != 0:
  - PC is not updated.
  - Fault is set (sticky until Reset).
  - State goes to S_HALT.
  - While Fault=1, Resume is ignored.
  - PID 0 (kernel) is exempt.
- Without the macro: no check is made; Fault is tied to 0.

Decomposition:
- Package fetch_pkg holds:
  - the state enum (S_BOOT, S_RUN, S_HALT);
  - WORD_W=32 and PID_W=5;
  - the derived NUM_PID = 2^PID_W.
- One sub-module, base_table: 32x32 register file with one synchronous write port and one combinational read port, reset to zero.

Test Plan:
- Boot copy: BOOT_WORDS=4, HD words 0..3 = 0xA0..0xA3 -> IM writes (0,0xA0)..(3,0xA3) on cycles 1..4; Running=1 and PC=0 on cycle 5; IM_Wr=0 afterwards.
- Relocation: base[3]=0x100, PID_CPU=3, PC=0x10 -> Endereco=0x110, DeslocamentoMemoria=0x100. Write base[3]=0x200 in the same cycle -> Endereco reads 0x110, then 0x210 the next cycle.
- Halt/resume: in S_RUN, PC=0x20, Halt=1 -> PC stays 0x20, Running=0. Resume together with Halt -> PC=0x21 next cycle, Running=1.
- Reset mid-boot: assert Reset at copy cycle 2, release -> copy restarts with HD_Addr=HD_BIOS_BASE, BootDone=0 until the full BOOT_WORDS+1 cycles complete.
- Wrap: base=0xFFFFFFF0, PC=0x20 -> Endereco=0x00000010.
- BOUNDS_CHECK_EN, PROC_LIMIT=1024: PID 2 with InputPC=1024 -> Fault=1, PC unchanged, S_HALT, Resume ignored. PID 0 with InputPC=1024 -> PC=1024, no fault.
